// File: rtl/cpc_busrq_arbiter.sv
// cpc_busrq_arbiter: round-robin arbiter sharing the CPC Z80 bus among three expansion slots
module cpc_busrq_arbiter #(
    parameter int HOLD_MAX    = 4096,
    parameter int SYNC_STAGES = 2
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [2:0] SLOT_BUSRQ_B,
    output logic [2:0] SLOT_BUSACK_B,
    output logic       BUSRQ_B,
    input  logic       BUSACK_B,
    output logic [1:0] GRANT_ID,
    output logic       BUSY,
    output logic       TIMEOUT
);
    localparam int CW = $clog2(HOLD_MAX);
    localparam logic [1:0] IDLE = 2'd0, REQ = 2'd1, GRANT = 2'd2, RELEASE = 2'd3;
    localparam logic [CW-1:0] CNT_LAST = CW'(HOLD_MAX - 1);

    logic [SYNC_STAGES-1:0][2:0] req_sync_q, req_sync_d;
    logic [SYNC_STAGES-1:0]      ack_sync_q, ack_sync_d;
    logic [1:0]    state_q, state_d, winner_q, winner_d, last_q, last_d, grant_id_q, grant_id_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    slot_busack_b_q, slot_busack_b_d, req;
    logic          busrq_b_q, busrq_b_d, busy_q, busy_d, timeout_q, timeout_d, ack;
    logic [1:0]    first, second, third, pick;

    function automatic logic [1:0] next_slot(input logic [1:0] s);
        return (s == 2'd2) ? 2'd0 : s + 2'd1;
    endfunction

    // shift the asynchronous active-low inputs through the synchroniser chains
    always_comb begin
        req_sync_d = {req_sync_q[SYNC_STAGES-2:0], SLOT_BUSRQ_B};
        ack_sync_d = {ack_sync_q[SYNC_STAGES-2:0], BUSACK_B};
        req        = ~req_sync_q[SYNC_STAGES-1];
        ack        = ~ack_sync_q[SYNC_STAGES-1];
    end

    // round-robin pick starting one past the slot that last held the bus
    always_comb begin
        first  = next_slot(last_q);
        second = next_slot(first);
        third  = next_slot(second);
        pick   = req[first] ? first : req[second] ? second : third;
    end

    // arbitration state machine, tenure counter and sticky timeout
    always_comb begin
        state_d   = state_q;
        winner_d  = winner_q;
        last_d    = last_q;
        cnt_d     = '0;
        timeout_d = timeout_q;
        case (state_q)
            IDLE: begin
                if (!ack && |req) begin
                    state_d  = REQ;
                    winner_d = pick;
                end
            end
            REQ: begin
                if (!req[winner_q]) state_d = RELEASE;
                else if (ack)       state_d = GRANT;
            end
            GRANT: begin
                if (!req[winner_q]) begin
                    state_d = RELEASE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = RELEASE;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                if (!ack) state_d = IDLE;
            end
        endcase
        if (state_d == RELEASE) last_d = winner_q;
    end

    // outputs decoded from the next state so they change on the transition edge
    always_comb begin
        busrq_b_d       = !(state_d == REQ || state_d == GRANT);
        slot_busack_b_d = (state_d == GRANT) ? ~(3'b001 << winner_d) : 3'b111;
        grant_id_d      = busrq_b_d ? 2'd3 : winner_d;
        busy_d          = state_d != IDLE;
    end

    // state registers with synchronous reset to the idle, bus-released condition
    always_ff @(posedge CLK) begin
        if (RESET) begin
            req_sync_q      <= '1;
            ack_sync_q      <= '1;
            state_q         <= IDLE;
            winner_q        <= 2'd0;
            last_q          <= 2'd2;
            cnt_q           <= '0;
            timeout_q       <= 1'b0;
            busrq_b_q       <= 1'b1;
            slot_busack_b_q <= 3'b111;
            grant_id_q      <= 2'd3;
            busy_q          <= 1'b0;
        end else begin
            req_sync_q      <= req_sync_d;
            ack_sync_q      <= ack_sync_d;
            state_q         <= state_d;
            winner_q        <= winner_d;
            last_q          <= last_d;
            cnt_q           <= cnt_d;
            timeout_q       <= timeout_d;
            busrq_b_q       <= busrq_b_d;
            slot_busack_b_q <= slot_busack_b_d;
            grant_id_q      <= grant_id_d;
            busy_q          <= busy_d;
        end
    end

    assign BUSRQ_B       = busrq_b_q;
    assign SLOT_BUSACK_B = slot_busack_b_q;
    assign GRANT_ID      = grant_id_q;
    assign BUSY          = busy_q;
    assign TIMEOUT       = timeout_q;
endmodule

// File: tb/tb_cpc_busrq_arbiter.sv
// tb_cpc_busrq_arbiter: vector table with scoreboard plus a reactive round-robin sequence
module tb_cpc_busrq_arbiter;
    localparam int K_I = 0, K_R = 1, K_G = 2, K_L = 3;

    typedef struct { logic rst; logic [2:0] rq_b; logic ak_b; logic [7:0] exp; } vec_t;
    typedef struct { int idx; logic [7:0] exp; } sb_t;

    logic       CLK = 1'b0, RESET = 1'b1, BUSACK_B = 1'b1;
    logic [2:0] SLOT_BUSRQ_B = 3'b111;
    logic [2:0] SLOT_BUSACK_B;
    logic       BUSRQ_B, BUSY, TIMEOUT;
    logic [1:0] GRANT_ID;
    vec_t vecs[$];
    sb_t  sb_q[$];
    int   total = 0, bad = 0;

    cpc_busrq_arbiter #(.HOLD_MAX(8), .SYNC_STAGES(2)) dut (
        .CLK(CLK), .RESET(RESET), .SLOT_BUSRQ_B(SLOT_BUSRQ_B), .SLOT_BUSACK_B(SLOT_BUSACK_B),
        .BUSRQ_B(BUSRQ_B), .BUSACK_B(BUSACK_B), .GRANT_ID(GRANT_ID), .BUSY(BUSY), .TIMEOUT(TIMEOUT)
    );

    always #5 CLK = ~CLK;

    // n cycles of the given inputs; expected {SLOT_BUSACK_B,BUSRQ_B,GRANT_ID,BUSY,TIMEOUT} after each edge
    function automatic void add(input logic r, input logic [2:0] rq, input logic ak, input int kind,
                                input logic [1:0] w, input logic t, input int n);
        logic [7:0] e;
        e = kind == K_I ? {3'b111, 1'b1, 2'd3, 1'b0, t} :
            kind == K_R ? {3'b111, 1'b0, w, 1'b1, t} :
            kind == K_G ? {~(3'b001 << w), 1'b0, w, 1'b1, t} :
                          {3'b111, 1'b1, 2'd3, 1'b1, t};
        for (int i = 0; i < n; i++) vecs.push_back('{r, rq, ak, e});
    endfunction

    // scoreboard: compare outputs just after each edge against the queued expectation
    always @(posedge CLK) begin
        #1;
        if (sb_q.size() > 0) begin
            sb_t s;
            s = sb_q.pop_front();
            total++;
            if ({SLOT_BUSACK_B, BUSRQ_B, GRANT_ID, BUSY, TIMEOUT} !== s.exp) begin
                bad++;
                $display("FAIL vec%0d sack_brq_gid_busy_to got=%b exp=%b", s.idx,
                         {SLOT_BUSACK_B, BUSRQ_B, GRANT_ID, BUSY, TIMEOUT}, s.exp);
            end
        end
    end

    // all slots request, each drops when acknowledged; Z80 mirrors BUSRQ_B
    task automatic run_rr();
        int   order[$];
        int   grants;
        logic idle_seen;
        logic [2:0] prev_s;
        grants = 0;
        idle_seen = 1'b0;
        prev_s = 3'b111;
        for (int i = 0; i < 6; i++) order.push_back(i % 3);
        @(negedge CLK);
        RESET = 1'b1; SLOT_BUSRQ_B = 3'b111; BUSACK_B = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
        for (int c = 0; c < 400 && order.size() > 0; c++) begin
            @(negedge CLK);
            if (!BUSY) idle_seen = 1'b1;
            if (SLOT_BUSACK_B != 3'b111 && prev_s == 3'b111) begin
                int g;
                int want;
                g = !SLOT_BUSACK_B[0] ? 0 : !SLOT_BUSACK_B[1] ? 1 : 2;
                want = order.pop_front();
                total++;
                if (g != want || GRANT_ID != 2'(want)) begin
                    bad++;
                    $display("FAIL rr_order grant#%0d got slot=%0d gid=%0d exp=%0d", grants, g, GRANT_ID, want);
                end
                if (grants > 0) begin
                    total++;
                    if (!idle_seen) begin
                        bad++;
                        $display("FAIL rr_gap grant#%0d got no idle cycle exp idle before grant", grants);
                    end
                end
                grants++;
                idle_seen = 1'b0;
            end
            prev_s = SLOT_BUSACK_B;
            BUSACK_B = BUSRQ_B;
            SLOT_BUSRQ_B = ~SLOT_BUSACK_B;
        end
        total++;
        if (order.size() != 0) begin
            bad++;
            $display("FAIL rr_done got grants=%0d exp=6", grants);
        end
        total++;
        if (TIMEOUT !== 1'b0) begin
            bad++;
            $display("FAIL rr_timeout got=%b exp=0", TIMEOUT);
        end
    endtask

    // build the vector table, drive it, then run the reactive sequence
    initial begin
        // single slot request, grant, release
        add(1, 3'b111, 1, K_I, 0, 0, 1);
        add(0, 3'b110, 1, K_I, 0, 0, 2);
        add(0, 3'b110, 1, K_R, 0, 0, 1);
        add(0, 3'b110, 0, K_R, 0, 0, 2);
        add(0, 3'b110, 0, K_G, 0, 0, 2);
        add(0, 3'b111, 0, K_G, 0, 0, 2);
        add(0, 3'b111, 0, K_L, 0, 0, 1);
        add(0, 3'b111, 1, K_L, 0, 0, 2);
        add(0, 3'b111, 1, K_I, 0, 0, 2);
        // slot 1 times out after 8 grant cycles, timeout sticky, slot stays eligible
        add(1, 3'b111, 1, K_I, 0, 0, 1);
        add(0, 3'b101, 1, K_I, 0, 0, 2);
        add(0, 3'b101, 1, K_R, 1, 0, 1);
        add(0, 3'b101, 0, K_R, 1, 0, 2);
        add(0, 3'b101, 0, K_G, 1, 0, 8);
        add(0, 3'b101, 1, K_L, 0, 1, 2);
        add(0, 3'b101, 1, K_I, 0, 1, 1);
        add(0, 3'b111, 1, K_R, 1, 1, 2);
        add(0, 3'b111, 1, K_L, 0, 1, 1);
        add(0, 3'b111, 1, K_I, 0, 1, 2);
        // reset clears timeout; slot 2 withdraws in REQ; reset mid-grant with Z80 still acking
        add(1, 3'b111, 1, K_I, 0, 0, 1);
        add(0, 3'b110, 1, K_I, 0, 0, 2);
        add(0, 3'b110, 0, K_R, 0, 0, 1);
        add(0, 3'b111, 0, K_R, 0, 0, 1);
        add(0, 3'b111, 0, K_G, 0, 0, 1);
        add(0, 3'b111, 0, K_L, 0, 0, 1);
        add(0, 3'b111, 1, K_L, 0, 0, 1);
        add(0, 3'b011, 1, K_L, 0, 0, 1);
        add(0, 3'b011, 1, K_I, 0, 0, 1);
        add(0, 3'b111, 1, K_R, 2, 0, 2);
        add(0, 3'b111, 1, K_L, 0, 0, 1);
        add(0, 3'b000, 1, K_I, 0, 0, 2);
        add(0, 3'b000, 1, K_R, 0, 0, 1);
        add(0, 3'b000, 0, K_R, 0, 0, 2);
        add(0, 3'b000, 0, K_G, 0, 0, 1);
        add(1, 3'b000, 0, K_I, 0, 0, 1);
        add(0, 3'b110, 0, K_I, 0, 0, 6);
        add(0, 3'b110, 1, K_I, 0, 0, 2);
        add(0, 3'b110, 1, K_R, 0, 0, 1);
        add(0, 3'b111, 1, K_R, 0, 0, 2);
        add(0, 3'b111, 1, K_L, 0, 0, 1);
        add(0, 3'b111, 1, K_I, 0, 0, 2);
        // withdrawal coincides with the last tenure cycle; ack glitch during grant ignored
        add(1, 3'b111, 1, K_I, 0, 0, 1);
        add(0, 3'b110, 1, K_I, 0, 0, 1);
        add(0, 3'b110, 0, K_I, 0, 0, 1);
        add(0, 3'b110, 0, K_R, 0, 0, 1);
        add(0, 3'b110, 0, K_G, 0, 0, 3);
        add(0, 3'b110, 1, K_G, 0, 0, 1);
        add(0, 3'b110, 0, K_G, 0, 0, 2);
        add(0, 3'b111, 0, K_G, 0, 0, 2);
        add(0, 3'b111, 1, K_L, 0, 0, 2);
        add(0, 3'b111, 1, K_I, 0, 0, 1);
        foreach (vecs[i]) begin
            @(negedge CLK);
            RESET = vecs[i].rst;
            SLOT_BUSRQ_B = vecs[i].rq_b;
            BUSACK_B = vecs[i].ak_b;
            sb_q.push_back('{i, vecs[i].exp});
        end
        repeat (2) @(negedge CLK);
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL sb_drain got pending=%0d exp=0", sb_q.size());
        end
        run_rr();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // hard stop if the run never reaches the summary
    initial begin
        #200000;
        $display("FAIL watchdog got no finish exp finish before 200us");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/cpc_busrq_arbiter.md
CPC_BUSRQ_ARBITER -- requirements
Module: cpc_busrq_arbiter

Interface
REQ-001 Parameter: HOLD_MAX, 4096, maximum clock cycles a slot may hold the bus per grant (range 2..65535).
REQ-002 Parameter: SYNC_STAGES, 2, number of synchroniser flops on each asynchronous input (minimum 2).
REQ-003 CLK  input  1  CPC bus clock (4 MHz); all logic on rising edge; one clock domain.
REQ-004 RESET  input  1  synchronous, active-high reset.
REQ-005 SLOT_BUSRQ_B  input  3  per-slot bus request from expansion sockets 1..3 (bit 0 = socket 1), active low, asynchronous.
REQ-006 SLOT_BUSACK_B  output  3  per-slot bus acknowledge, active low, registered.
REQ-007 BUSRQ_B  output  1  bus request to CPC Z80, active low, registered.
REQ-008 BUSACK_B  input  1  bus acknowledge from CPC Z80, active low, asynchronous.
REQ-009 GRANT_ID  output  2  index of granted slot (0..2); 3 = none.
REQ-010 BUSY  output  1  high in any state other than IDLE.
REQ-011 TIMEOUT  output  1  sticky flag: a grant was forcibly ended at HOLD_MAX.

Function
REQ-012 SLOT_BUSRQ_B and BUSACK_B shall each pass through SYNC_STAGES flops (reset value 1) before use; below, "req[i]" and "ack" denote synchronised, active-high versions.
REQ-013 FSM states: IDLE, REQ, GRANT, RELEASE; all outputs registered and decoded from next state.
REQ-014 IDLE: if ack is low and any req[i] is high, select winner by round-robin and go to REQ; else stay.
REQ-015 IDLE with ack high (Z80 still acknowledging, e.g. after reset mid-grant): no new request until ack falls.
REQ-016 Round-robin: priority starts at slot (last+1) mod 3; last is updated to the winner on entry to RELEASE; last resets to 2, so slot 0 wins first.
REQ-017 REQ: BUSRQ_B=0, SLOT_BUSACK_B=111, GRANT_ID=winner; on ack high go to GRANT; if req[winner] falls before ack, go to RELEASE.
REQ-018 GRANT: BUSRQ_B=0, SLOT_BUSACK_B[winner]=0 (others 1); tenure counter increments each cycle from 0.
REQ-019 GRANT exit: req[winner] low -> RELEASE; counter reaching HOLD_MAX-1 with req still high -> RELEASE and TIMEOUT set to 1.
REQ-020 Both exit conditions in the same cycle: RELEASE, TIMEOUT not set.
REQ-021 RELEASE: BUSRQ_B=1, SLOT_BUSACK_B=111, GRANT_ID=3; stay until ack low, then IDLE; counter cleared.
REQ-022 Requests from other slots arriving in REQ/GRANT/RELEASE are held pending; they are evaluated only in IDLE, with a minimum of one IDLE cycle between grants.
REQ-023 A slot whose grant timed out remains eligible; round-robin passes to other requesters first.
REQ-024 Latency: slot request sampled low at edge k -> BUSRQ_B low after edge k+SYNC_STAGES (k+2 with defaults); BUSACK_B sampled low at edge j -> SLOT_BUSACK_B low after edge j+SYNC_STAGES.
REQ-025 ack dropping unexpectedly in GRANT (Z80 reset): SLOT_BUSACK_B held until the winner releases or timeout; no other effect.
REQ-026 Counter width ceil(log2(HOLD_MAX)); it shall never wrap.

Reset
REQ-027 RESET high at an edge: state IDLE, BUSRQ_B=1, SLOT_BUSACK_B=111, GRANT_ID=3, BUSY=0, TIMEOUT=0, last=2, counter=0, sync flops=1.
REQ-028 RESET asserted mid-grant releases all outputs at the next edge; REQ-015 prevents re-request until the Z80 drops BUSACK_B.
REQ-029 TIMEOUT is cleared only by RESET.

Verification
REQ-030 Single slot: SLOT_BUSRQ_B=110 at edge 10 -> BUSRQ_B=0 after edge 12; BUSACK_B=0 at edge 15 -> SLOT_BUSACK_B=110, GRANT_ID=0 after edge 17; release -> BUSRQ_B=1, then IDLE after BUSACK_B=1.
REQ-031 All three request continuously with short tenures -> grant order 0,1,2,0,1,2; at least one IDLE cycle between grants.
REQ-032 HOLD_MAX=8, slot 1 holds request -> SLOT_BUSACK_B[1] deasserted after 8 GRANT cycles, TIMEOUT=1 and stays 1 until RESET.
REQ-033 Slot 2 withdraws request in REQ before BUSACK_B -> RELEASE, BUSRQ_B=1, no SLOT_BUSACK_B pulse, last=2.
REQ-034 RESET during GRANT with BUSACK_B held low 20 cycles, slot 0 requesting -> all outputs inactive next edge; BUSRQ_B stays 1 until 2 edges after BUSACK_B rises, then re-request.
REQ-035 Withdrawal and timeout in the same GRANT cycle -> RELEASE, TIMEOUT stays 0.
